// File: rtl/pwm_compare_stage.sv
// -----------------------------------------------------------------------------
// pwm_compare_stage
//
// Turns the value of a free-running N-bit period counter into a registered,
// glitch-free PWM waveform. A double-buffered duty register means a new duty
// value is applied only at a period boundary (counter wrap). A small run-control
// FSM makes the output start and stop only on whole periods.
//
// Ports:
//   clk           in   1    system clock, rising edge
//   reset         in   1    asynchronous reset, active low
//   count         in   N    current value of the upstream period counter
//   enable        in   1    run request (level)
//   duty_in       in   N+1  requested high time in counts, saturated to 2^N
//   duty_wr       in   1    single-cycle write strobe for duty_in
//   pwm_out       out  1    registered PWM output
//   period_start  out  1    one-cycle pulse on each wrap seen while ARM/RUN
//   duty_pending  out  1    a written duty value is waiting for the next wrap
//   running       out  1    FSM is in RUN
// -----------------------------------------------------------------------------
module pwm_compare_stage #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] count,
   input  logic         enable,
   input  logic [N:0]   duty_in,
   input  logic         duty_wr,
   output logic         pwm_out,
   output logic         period_start,
   output logic         duty_pending,
   output logic         running
);

   // Full-period duty: output stays high for every count of the period.
   localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e         state_q,        state_d;
   logic [N-1:0]   prev_count_q;
   logic [N:0]     active_duty_q,  active_duty_d;
   logic [N:0]     pending_duty_q, pending_duty_d;
   logic           duty_pending_q, duty_pending_d;
   logic           pwm_q,          pwm_d;
   logic           period_start_q, period_start_d;
   logic           running_q,      running_d;

   // ---------------------------------------------------------------------------
   // Derived signals
   // ---------------------------------------------------------------------------
   logic           wrap;
   logic           armed;
   logic           transfer;
   logic [N:0]     duty_sat;
   logic [N:0]     active_duty_eff;

   // A wrap is the only way the counter can go backwards; a stalled or
   // repeating counter never satisfies the strict compare.
   assign wrap     = (count < prev_count_q);
   assign armed    = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign transfer = wrap && armed && duty_pending_q;
   assign duty_sat = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

   // The compare on a boundary edge must already see the duty being loaded on
   // that same edge, otherwise the first count of the new period would use the
   // old value.
   assign active_duty_eff = transfer ? pending_duty_q : active_duty_q;

   // ---------------------------------------------------------------------------
   // Run-control FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path can
      // leave it unassigned, which would infer a latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (!enable)   state_d = ST_IDLE;
            else if (wrap) state_d = ST_RUN;
         end
         ST_RUN: begin
            // Dropping enable mid-period is ignored until the boundary so the
            // current period always completes.
            if (wrap && !enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Duty buffering and output next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      active_duty_d  = active_duty_eff;
      pending_duty_d = pending_duty_q;
      duty_pending_d = duty_pending_q;

      // A write on the boundary cycle is captured after the old pending value
      // has been handed to active_duty, so it waits for the following wrap.
      if (duty_wr) begin
         pending_duty_d = duty_sat;
         duty_pending_d = 1'b1;
      end else if (transfer) begin
         duty_pending_d = 1'b0;
      end

      // Keyed on the next state so the first high count of a period lines up
      // with period_start, and a stop at the boundary forces low on that edge.
      pwm_d          = (state_d == ST_RUN) && ({1'b0, count} < active_duty_eff);
      period_start_d = wrap && armed;
      running_d      = (state_d == ST_RUN);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         prev_count_q   <= '0;
         active_duty_q  <= '0;
         pending_duty_q <= '0;
         duty_pending_q <= 1'b0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         running_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q        <= state_d;
         prev_count_q   <= count;
         active_duty_q  <= active_duty_d;
         pending_duty_q <= pending_duty_d;
         duty_pending_q <= duty_pending_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
         running_q      <= running_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign duty_pending = duty_pending_q;
   assign running      = running_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// -----------------------------------------------------------------------------
// tb_pwm_compare_stage
//
// Directed bench for pwm_compare_stage with N=4 (16 counts per period). The
// bench plays the role of the upstream counter by driving count directly.
// Outputs are sampled 1 time unit after each rising edge; inputs are changed
// at that point too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pwm_compare_stage;

   localparam int N = 4;

   logic         clk;
   logic         reset;
   logic [N-1:0] count;
   logic         enable;
   logic [N:0]   duty_in;
   logic         duty_wr;
   logic         pwm_out;
   logic         period_start;
   logic         duty_pending;
   logic         running;

   int errors = 0;
   int checks = 0;
   int highs  = 0;

   pwm_compare_stage #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .count        (count),
      .enable       (enable),
      .duty_in      (duty_in),
      .duty_wr      (duty_wr),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty_pending (duty_pending),
      .running      (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive counts first..last. Expected pwm is (count < duty) while in RUN,
   // period_start is expected on count 0 (which always follows 15 here).
   task automatic span(input int first, input int last, input int duty,
                       input logic run, input string tag);
      for (int c = first; c <= last; c++) begin
         count = 4'(c);
         tick();
         check_bit($sformatf("%s pwm c=%0d", tag, c), pwm_out, run && (c < duty));
         check_bit($sformatf("%s ps c=%0d", tag, c), period_start, run && (c == 0));
         check_bit($sformatf("%s run c=%0d", tag, c), running, run);
         if (pwm_out) highs++;
      end
   endtask

   // One full RUN period with a given active duty, optionally writing a new
   // duty value at count wr_at (wr_at < 0 means no write).
   task automatic period_wr(input int duty, input int exp_highs, input int wr_at,
                            input logic [N:0] wr_val, input string tag);
      highs = 0;
      if (wr_at < 0) begin
         span(0, 15, duty, 1'b1, tag);
      end else begin
         if (wr_at > 0) span(0, wr_at - 1, duty, 1'b1, tag);
         duty_in = wr_val;
         duty_wr = 1'b1;
         span(wr_at, wr_at, duty, 1'b1, tag);
         duty_wr = 1'b0;
         check_bit({tag, " pending after write"}, duty_pending, 1'b1);
         span(wr_at + 1, 15, duty, 1'b1, tag);
      end
      check_int({tag, " high count"}, highs, exp_highs);
   endtask

   initial begin
      reset   = 1'b0;
      count   = '0;
      enable  = 1'b0;
      duty_in = '0;
      duty_wr = 1'b0;

      // ---- Reset state ----
      #12;
      check_bit("reset pwm", pwm_out, 1'b0);
      check_bit("reset ps", period_start, 1'b0);
      check_bit("reset pending", duty_pending, 1'b0);
      check_bit("reset running", running, 1'b0);
      reset = 1'b1;

      // ---- Basic duty 5 ----
      duty_in = 5'd5;
      duty_wr = 1'b1;
      tick();
      duty_wr = 1'b0;
      check_bit("write5 pending", duty_pending, 1'b1);
      check_bit("write5 idle", running, 1'b0);
      enable = 1'b1;
      span(1, 15, 5, 1'b0, "arm");
      check_bit("arm keeps pending", duty_pending, 1'b1);
      count = 4'd0;
      tick();
      check_bit("first wrap pwm", pwm_out, 1'b1);
      check_bit("first wrap ps", period_start, 1'b1);
      check_bit("first wrap running", running, 1'b1);
      check_bit("first wrap pending cleared", duty_pending, 1'b0);
      highs = 1;
      span(1, 15, 5, 1'b1, "duty5a");
      check_int("duty5a high count", highs, 5);

      // ---- Double buffering: write 12 at count 7 ----
      period_wr(5, 5, 7, 5'd12, "duty5b");
      count = 4'd0;
      tick();
      check_bit("dbuf wrap pending cleared", duty_pending, 1'b0);
      check_bit("dbuf wrap pwm", pwm_out, 1'b1);
      highs = 1;
      // Duty 12 period also queues 3 at count 5.
      duty_in = 5'd3;
      duty_wr = 1'b1;
      span(1, 5, 12, 1'b1, "duty12");
      duty_wr = 1'b0;
      span(6, 15, 12, 1'b1, "duty12");
      check_int("duty12 high count", highs, 12);

      // ---- Write 9 on the wrap cycle while 3 is pending ----
      duty_in = 5'd9;
      duty_wr = 1'b1;
      count   = 4'd0;
      tick();
      duty_wr = 1'b0;
      check_bit("wrwrap pending held", duty_pending, 1'b1);
      check_bit("wrwrap pwm", pwm_out, 1'b1);
      check_bit("wrwrap ps", period_start, 1'b1);
      highs = 1;
      span(1, 15, 3, 1'b1, "duty3");
      check_int("duty3 high count", highs, 3);
      check_bit("duty3 pending still", duty_pending, 1'b1);
      period_wr(9, 9, 4, 5'd0, "duty9");

      // ---- Extremes: 0, 16, 20 (saturates to 16) ----
      period_wr(0, 0, 4, 5'd16, "duty0");
      period_wr(16, 16, 4, 5'd20, "duty16");
      period_wr(16, 16, 4, 5'd8, "duty20sat");

      // ---- Stall at count 6 for 10 cycles with duty 8 ----
      highs = 0;
      span(0, 6, 8, 1'b1, "stall");
      for (int i = 0; i < 10; i++) begin
         count = 4'd6;
         tick();
         check_bit($sformatf("stall hold pwm %0d", i), pwm_out, 1'b1);
         check_bit($sformatf("stall no ps %0d", i), period_start, 1'b0);
         check_bit($sformatf("stall running %0d", i), running, 1'b1);
      end
      span(7, 15, 8, 1'b1, "stall");
      check_int("stall high count", highs, 8);

      // ---- Drop enable at count 2: period completes, IDLE at wrap ----
      highs = 0;
      span(0, 1, 8, 1'b1, "stop");
      enable = 1'b0;
      span(2, 15, 8, 1'b1, "stop");
      check_int("stop high count", highs, 8);
      count = 4'd0;
      tick();
      check_bit("stop wrap pwm", pwm_out, 1'b0);
      check_bit("stop wrap running", running, 1'b0);
      check_bit("stop wrap ps", period_start, 1'b1);
      count = 4'd1;
      tick();
      check_bit("idle ps", period_start, 1'b0);
      check_bit("idle running", running, 1'b0);

      // ---- Restart, then reset mid-period with pwm high at count 3 ----
      enable = 1'b1;
      span(2, 15, 8, 1'b0, "rearm");
      span(0, 2, 8, 1'b1, "rerun");
      duty_in = 5'd10;
      duty_wr = 1'b1;
      span(3, 3, 8, 1'b1, "rerun");
      duty_wr = 1'b0;
      check_bit("pre-reset pending", duty_pending, 1'b1);
      #2 reset = 1'b0;
      #1;
      check_bit("async reset pwm", pwm_out, 1'b0);
      check_bit("async reset pending", duty_pending, 1'b0);
      check_bit("async reset running", running, 1'b0);
      #1 reset = 1'b1;

      // After release: waits in ARM (active duty is 0 after reset).
      span(4, 7, 0, 1'b0, "post-reset arm");
      duty_in = 5'd6;
      duty_wr = 1'b1;
      span(8, 8, 0, 1'b0, "post-reset arm");
      duty_wr = 1'b0;
      span(9, 15, 0, 1'b0, "post-reset arm");
      check_bit("post-reset pending", duty_pending, 1'b1);
      period_wr(6, 6, -1, 5'd0, "post-reset duty6");
      check_bit("post-reset pending cleared", duty_pending, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
